// File: rtl/div_pkg.sv
// Shared constants and state encoding for the 8-bit sequential divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 8;
  localparam int unsigned DIV_STEPS = 8;
  localparam int unsigned CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's complement negation at divider width.
  function automatic logic [DIV_WIDTH-1:0] neg8(input logic [DIV_WIDTH-1:0] x);
    return DIV_WIDTH'(~x + DIV_WIDTH'(1));
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {r,q} left, trial-subtract divisor, restore on borrow.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH:0]   r,
  input  logic [DIV_WIDTH-1:0] q,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH:0]   r_next,
  output logic [DIV_WIDTH-1:0] q_next
);

  logic [DIV_WIDTH:0] r_sh;
  logic [DIV_WIDTH:0] t;

  // r stays below divisor, so dropping its top bit on the shift loses nothing.
  always_comb begin
    r_sh = (DIV_WIDTH + 1)'({r, q[DIV_WIDTH-1]});
    t    = r_sh - {1'b0, divisor};
    if (!t[DIV_WIDTH]) begin
      r_next = t;
      q_next = {q[DIV_WIDTH-2:0], 1'b1};
    end else begin
      r_next = r_sh;
      q_next = {q[DIV_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/eight_bit_seq_divider.sv
// 8-bit multi-cycle restoring divider: IDLE/RUN/DONE FSM around div_step.
// Define DIV_SIGNED_EN for two's complement operands (magnitude core + sign fix-up).
module eight_bit_seq_divider
  import div_pkg::*;
(
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 ctrl_div,
  input  logic [DIV_WIDTH-1:0] data_operandA,
  input  logic [DIV_WIDTH-1:0] data_operandB,
  output logic [DIV_WIDTH-1:0] data_result,
  output logic [DIV_WIDTH-1:0] data_remainder,
  output logic                 data_exception,
  output logic                 data_resultRDY,
  output logic                 busy
);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [DIV_WIDTH:0]   rem;
  logic [DIV_WIDTH-1:0] quo;
  logic [DIV_WIDTH-1:0] dvs;
  logic [DIV_WIDTH:0]   rem_nx;
  logic [DIV_WIDTH-1:0] quo_nx;
  logic [DIV_WIDTH-1:0] mag_a;
  logic [DIV_WIDTH-1:0] mag_b;
  logic [DIV_WIDTH-1:0] q_fix;
  logic [DIV_WIDTH-1:0] r_fix;
  logic                 ovf_fix;

  div_step u_step (
    .r       (rem),
    .q       (quo),
    .divisor (dvs),
    .r_next  (rem_nx),
    .q_next  (quo_nx)
  );

`ifdef DIV_SIGNED_EN
  logic q_neg;
  logic r_neg;
  logic ovf;

  // Core works on magnitudes; signs are reapplied as the result is registered.
  always_comb begin
    mag_a   = data_operandA[DIV_WIDTH-1] ? neg8(data_operandA) : data_operandA;
    mag_b   = data_operandB[DIV_WIDTH-1] ? neg8(data_operandB) : data_operandB;
    q_fix   = q_neg ? neg8(quo_nx) : quo_nx;
    r_fix   = r_neg ? neg8(rem_nx[DIV_WIDTH-1:0]) : rem_nx[DIV_WIDTH-1:0];
    ovf_fix = ovf;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && ctrl_div) begin
      q_neg <= data_operandA[DIV_WIDTH-1] ^ data_operandB[DIV_WIDTH-1];
      r_neg <= data_operandA[DIV_WIDTH-1];
      ovf   <= (data_operandA == 8'h80) && (data_operandB == 8'hFF);
    end
  end
`else
  always_comb begin
    mag_a   = data_operandA;
    mag_b   = data_operandB;
    q_fix   = quo_nx;
    r_fix   = rem_nx[DIV_WIDTH-1:0];
    ovf_fix = 1'b0;
  end
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      cnt            <= '0;
      rem            <= '0;
      quo            <= '0;
      dvs            <= '0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
          if (ctrl_div) begin
            dvs            <= mag_b;
            cnt            <= '0;
            busy           <= 1'b1;
            data_exception <= 1'b0;
            if (data_operandB == '0) begin
              // Divide-by-zero short-circuits straight to DONE.
              data_result    <= '0;
              data_remainder <= data_operandA;
              data_exception <= 1'b1;
              data_resultRDY <= 1'b1;
              state          <= DONE;
            end else begin
              rem   <= '0;
              quo   <= mag_a;
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + CNT_WIDTH'(1);
          if (cnt == CNT_WIDTH'(DIV_STEPS - 1)) begin
            data_result    <= q_fix;
            data_remainder <= r_fix;
            data_exception <= ovf_fix;
            data_resultRDY <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eight_bit_seq_divider.sv
// Directed self-checking bench for eight_bit_seq_divider (DIV_SIGNED_EN selects signed expectations).
module tb_eight_bit_seq_divider;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ctrl_div = 1'b0;
  logic [7:0] data_operandA = 8'h00;
  logic [7:0] data_operandB = 8'h00;
  logic [7:0] data_result;
  logic [7:0] data_remainder;
  logic       data_exception;
  logic       data_resultRDY;
  logic       busy;

  int checks = 0;
  int errors = 0;

  eight_bit_seq_divider dut (
    .clock          (clock),
    .resetn         (resetn),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Issue one op and watch until one cycle past the strobe; ends #1 into an IDLE cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat,
                        output logic [7:0] q, output logic [7:0] r, output logic e,
                        output int busy_cnt, output int rdy_cnt);
    @(negedge clock);
    ctrl_div = 1'b1; data_operandA = a; data_operandB = b;
    @(posedge clock); #1;
    ctrl_div = 1'b0;
    lat = 0; busy_cnt = 0; rdy_cnt = 0; q = 8'h00; r = 8'h00; e = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (busy) busy_cnt++;
      if (data_resultRDY) begin
        rdy_cnt++;
        if (lat == 0) begin
          lat = c; q = data_result; r = data_remainder; e = data_exception;
        end
      end
      if (lat != 0 && c > lat) break;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({data_result, data_remainder, data_exception, data_resultRDY, busy} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got q=%h r=%h e=%b rdy=%b busy=%b, want all zero",
               data_result, data_remainder, data_exception, data_resultRDY, busy);
    end
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b rdy=%b, want 0 0", busy, data_resultRDY);
    end
  endtask

  task automatic test_basic();
    int lat, bc, rc; logic [7:0] q, r; logic e;
    run_op(8'd100, 8'd7, lat, q, r, e, bc, rc);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d, want 9", lat); end
    checks++;
    if (q !== 8'd14 || r !== 8'd2 || e !== 1'b0) begin
      errors++; $display("FAIL basic_100_7: got q=%0d r=%0d e=%b, want q=14 r=2 e=0", q, r, e);
    end
    checks++;
    if (bc !== 9) begin errors++; $display("FAIL basic_busy_cycles: got %0d, want 9", bc); end
    checks++;
    if (rc !== 1) begin errors++; $display("FAIL basic_strobe_count: got %0d, want 1", rc); end
    checks++;
    if (data_result !== 8'd14 || data_remainder !== 8'd2) begin
      errors++; $display("FAIL basic_hold: got q=%0d r=%0d, want 14 2", data_result, data_remainder);
    end
  endtask

  task automatic test_div_zero();
    int lat, bc, rc; logic [7:0] q, r; logic e;
    run_op(8'd5, 8'd0, lat, q, r, e, bc, rc);
    checks++;
    if (lat !== 1 || bc !== 1) begin
      errors++; $display("FAIL dz_latency: got lat=%0d busy=%0d, want 1 1", lat, bc);
    end
    checks++;
    if (q !== 8'd0 || r !== 8'd5 || e !== 1'b1) begin
      errors++; $display("FAIL dz_5_0: got q=%0d r=%0d e=%b, want 0 5 1", q, r, e);
    end
    run_op(8'd255, 8'd1, lat, q, r, e, bc, rc);
    checks++;
`ifdef DIV_SIGNED_EN
    if (lat !== 9 || q !== 8'hFF || r !== 8'd0 || e !== 1'b0) begin
      errors++; $display("FAIL dz_next_op: got lat=%0d q=%h r=%h e=%b, want 9 ff 00 0", lat, q, r, e);
    end
`else
    if (lat !== 9 || q !== 8'd255 || r !== 8'd0 || e !== 1'b0) begin
      errors++; $display("FAIL dz_next_op: got lat=%0d q=%0d r=%0d e=%b, want 9 255 0 0", lat, q, r, e);
    end
`endif
  endtask

  task automatic test_ignore_start();
    int rc = 0; logic [7:0] q = 8'h00, r = 8'h00;
    logic [7:0] want_q, want_r;
`ifdef DIV_SIGNED_EN
    want_q = 8'hEE; want_r = 8'hFE;
`else
    want_q = 8'd66; want_r = 8'd2;
`endif
    @(negedge clock);
    ctrl_div = 1'b1; data_operandA = 8'd200; data_operandB = 8'd3;
    @(posedge clock); #1;
    ctrl_div = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (data_resultRDY) begin
        rc++; q = data_result; r = data_remainder;
      end
      if (c == 3) begin ctrl_div = 1'b1; data_operandA = 8'd9; data_operandB = 8'd9; end
      if (c == 4) ctrl_div = 1'b0;
      @(posedge clock); #1;
    end
    checks++;
    if (rc !== 1) begin errors++; $display("FAIL ignore_strobes: got %0d, want 1", rc); end
    checks++;
    if (q !== want_q || r !== want_r || data_result !== want_q) begin
      errors++; $display("FAIL ignore_result: got q=%h r=%h out=%h, want q=%h r=%h",
                         q, r, data_result, want_q, want_r);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, rc; logic [7:0] q, r; logic e;
    int strobes = 0;
    @(negedge clock);
    ctrl_div = 1'b1; data_operandA = 8'd77; data_operandB = 8'd5;
    @(posedge clock); #1;
    ctrl_div = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    resetn = 1'b0;
    #1;
    checks++;
    if ({data_result, data_remainder, data_exception, data_resultRDY, busy} !== 19'd0) begin
      errors++;
      $display("FAIL midrun_reset: got q=%h r=%h e=%b rdy=%b busy=%b, want all zero",
               data_result, data_remainder, data_exception, data_resultRDY, busy);
    end
    @(negedge clock); resetn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); #1;
      if (data_resultRDY || busy) strobes++;
    end
    checks++;
    if (strobes !== 0) begin errors++; $display("FAIL midrun_no_strobe: got %0d active cycles, want 0", strobes); end
    run_op(8'd77, 8'd5, lat, q, r, e, bc, rc);
    checks++;
    if (lat !== 9 || q !== 8'd15 || r !== 8'd2 || e !== 1'b0) begin
      errors++; $display("FAIL midrun_restart: got lat=%0d q=%0d r=%0d e=%b, want 9 15 2 0", lat, q, r, e);
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    logic [7:0] va [4] = '{8'h9C, 8'd100, 8'h80, 8'hF9};
    logic [7:0] vb [4] = '{8'd7, 8'hF9, 8'hFF, 8'h00};
    logic [7:0] vq [4] = '{8'hF2, 8'hF2, 8'h80, 8'h00};
    logic [7:0] vr [4] = '{8'hFE, 8'h02, 8'h00, 8'hF9};
    logic       ve [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int         vl [4] = '{9, 9, 9, 1};
    int lat, bc, rc; logic [7:0] q, r; logic e;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], lat, q, r, e, bc, rc);
      checks++;
      if (lat !== vl[i] || q !== vq[i] || r !== vr[i] || e !== ve[i]) begin
        errors++;
        $display("FAIL signed_%0d: %h/%h got lat=%0d q=%h r=%h e=%b, want lat=%0d q=%h r=%h e=%b",
                 i, va[i], vb[i], lat, q, r, e, vl[i], vq[i], vr[i], ve[i]);
      end
    end
  endtask
`else
  task automatic test_vectors();
    logic [7:0] va [6] = '{8'd255, 8'd7,   8'd0, 8'd128, 8'd255, 8'd1};
    logic [7:0] vb [6] = '{8'd255, 8'd100, 8'd1, 8'd16,  8'd2,   8'd0};
    logic [7:0] vq [6] = '{8'd1,   8'd0,   8'd0, 8'd8,   8'd127, 8'd0};
    logic [7:0] vr [6] = '{8'd0,   8'd7,   8'd0, 8'd0,   8'd1,   8'd1};
    logic       ve [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int lat, bc, rc; logic [7:0] q, r; logic e;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], lat, q, r, e, bc, rc);
      checks++;
      if (q !== vq[i] || r !== vr[i] || e !== ve[i]) begin
        errors++;
        $display("FAIL vector_%0d: %0d/%0d got q=%0d r=%0d e=%b, want q=%0d r=%0d e=%b",
                 i, va[i], vb[i], q, r, e, vq[i], vr[i], ve[i]);
      end
    end
  endtask
`endif

  // Strided sweep against a behavioural reference, including every dividend row with divisor 0.
  task automatic test_sweep();
    int lat, bc, rc; logic [7:0] q, r; logic e;
    logic [7:0] a, b, mq, mr; logic me;
    int sa, sb;
    for (int ia = 0; ia < 256; ia += 15) begin
      for (int ib = 0; ib < 256; ib += 9) begin
        a = 8'(ia); b = 8'(ib);
        if (b == 8'd0) begin
          mq = 8'd0; mr = a; me = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
          sa = int'($signed(a)); sb = int'($signed(b));
          if (a == 8'h80 && b == 8'hFF) begin mq = 8'h80; mr = 8'h00; me = 1'b1; end
          else begin mq = 8'(sa / sb); mr = 8'(sa % sb); me = 1'b0; end
`else
          sa = ia; sb = ib;
          mq = 8'(sa / sb); mr = 8'(sa % sb); me = 1'b0;
`endif
        end
        run_op(a, b, lat, q, r, e, bc, rc);
        checks++;
        if (q !== mq || r !== mr || e !== me || lat !== ((b == 8'd0) ? 1 : 9)) begin
          errors++;
          $display("FAIL sweep %h/%h: got q=%h r=%h e=%b lat=%0d, want q=%h r=%h e=%b",
                   a, b, q, r, e, lat, mq, mr, me);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_run();
`ifdef DIV_SIGNED_EN
    test_signed();
`else
    test_vectors();
`endif
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
